// File: rtl/xuly_mod_chinh.sv
// xuly_mod_chinh: upstream control stage of the clock-adjust path.
// - Debounces the MODE (btn_mod) and UP (btn_tang) push-buttons.
// - Runs the adjust-mode FSM: 00 none, 01 seconds, 10 minutes, 11 hours.
// - Turns accepted UP presses into one-clock increment pulses for the selected field.
// - Falls back to mode 00 after TIMEOUT_MS of inactivity.
// Optional feature macro: AUTO_REPEAT_EN.
//   When defined, a held UP button keeps producing increment pulses
//   (first after REP_DELAY_MS, then every REP_RATE_MS).
module xuly_mod_chinh #(
  parameter int CLK_DIV      = 125000,
  parameter int DEB_MS       = 20,
  parameter int TIMEOUT_MS   = 10000,
  parameter int REP_DELAY_MS = 500,
  parameter int REP_RATE_MS  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mod,
  input  logic       btn_tang,
  output logic [1:0] gt_mod,
  output logic       inc_giay,
  output logic       inc_phut,
  output logic       inc_gio,
  output logic       adj_active
);

  // Prescaler width; a divider of 1 still needs a 1-bit counter.
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Debounce counter only needs to reach DEB_MS.
  localparam int DW = $clog2(DEB_MS + 1);
  // Shared width for the long millisecond counters (idle and auto-repeat).
  localparam int MS_MAX0 = (TIMEOUT_MS > REP_DELAY_MS) ? TIMEOUT_MS : REP_DELAY_MS;
  localparam int MS_MAX  = (MS_MAX0 > REP_RATE_MS) ? MS_MAX0 : REP_RATE_MS;
  localparam int MSW     = $clog2(MS_MAX + 1);

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_SEC  = 2'b01,
    MODE_MIN  = 2'b10,
    MODE_HOUR = 2'b11
  } mode_e;

  // Button index 0 = MODE, 1 = UP.
  logic [1:0]     sync1_r;
  logic [1:0]     sync2_r;
  logic [PW-1:0]  presc_r;
  logic [DW-1:0]  deb_cnt_r [2];
  logic [1:0]     deb_r;
  logic [1:0]     deb_q_r;
  logic [1:0]     lock_r;
  logic [MSW-1:0] idle_r;
  mode_e          mode_r;

  logic           tick_s;
  logic [1:0]     press_s;
  logic           mod_press_s;
  logic           up_press_s;
  logic           up_accept_s;
  logic           timeout_s;
  logic           rep_fire_s;
  mode_e          next_mode_s;

`ifdef AUTO_REPEAT_EN
  logic [MSW-1:0] rep_cnt_r;
  logic           rep_armed_r;
  logic           rep_first_r;
  logic [MSW-1:0] rep_target_s;
`endif

  assign gt_mod = mode_r;

  // Two-flop synchronisers; left unreset so they track the buttons during reset.
  always_ff @(posedge clk) begin
    sync1_r <= {btn_tang, btn_mod};
    sync2_r <= sync1_r;
  end

  // Millisecond prescaler: counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= {PW{1'b0}};
    end else if (presc_r == PW'(CLK_DIV - 1)) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Per-button debounce; lock_r hides a press that was already held across reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        deb_cnt_r[i] <= {DW{1'b0}};
      end
      deb_r   <= 2'b00;
      deb_q_r <= 2'b00;
      lock_r  <= 2'b11;
    end else begin
      deb_q_r <= deb_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= {DW{1'b0}};
        end else if (tick_s) begin
          if (deb_cnt_r[i] == DW'(DEB_MS - 1)) begin
            deb_r[i]     <= sync2_r[i];
            deb_cnt_r[i] <= {DW{1'b0}};
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
          end
        end
        // A button is armed again once it has been seen released and settled.
        if (!sync2_r[i] && !deb_r[i]) begin
          lock_r[i] <= 1'b0;
        end
      end
    end
  end

  // Strobes, next-mode decode and timeout/repeat qualifiers.
  always_comb begin
    tick_s      = (presc_r == PW'(CLK_DIV - 1));
    press_s     = deb_r & ~deb_q_r & ~lock_r;
    mod_press_s = press_s[0];
    up_press_s  = press_s[1];
    next_mode_s = MODE_NONE;
    case (mode_r)
      MODE_NONE: next_mode_s = MODE_SEC;
      MODE_SEC:  next_mode_s = MODE_MIN;
      MODE_MIN:  next_mode_s = MODE_HOUR;
      MODE_HOUR: next_mode_s = MODE_NONE;
      default:   next_mode_s = MODE_NONE;
    endcase
    // A mode step in the same clock swallows the UP press.
    if (up_press_s && !mod_press_s && (mode_r != MODE_NONE)) begin
      up_accept_s = 1'b1;
    end else begin
      up_accept_s = 1'b0;
    end
    timeout_s = (idle_r == MSW'(TIMEOUT_MS));
`ifdef AUTO_REPEAT_EN
    if (rep_first_r) begin
      rep_target_s = MSW'(REP_DELAY_MS - 1);
    end else begin
      rep_target_s = MSW'(REP_RATE_MS - 1);
    end
    if (rep_armed_r && tick_s && deb_r[1] && !mod_press_s &&
        (mode_r != MODE_NONE) && (rep_cnt_r == rep_target_s)) begin
      rep_fire_s = 1'b1;
    end else begin
      rep_fire_s = 1'b0;
    end
`else
    rep_fire_s = 1'b0;
`endif
  end

`ifdef AUTO_REPEAT_EN
  // Auto-repeat timer: armed by an accepted UP press, dropped on release or mode change.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_r   <= {MSW{1'b0}};
      rep_armed_r <= 1'b0;
      rep_first_r <= 1'b0;
    end else if (up_accept_s) begin
      rep_cnt_r   <= {MSW{1'b0}};
      rep_armed_r <= 1'b1;
      rep_first_r <= 1'b1;
    end else if (!deb_r[1] || mod_press_s || (mode_r == MODE_NONE)) begin
      rep_cnt_r   <= {MSW{1'b0}};
      rep_armed_r <= 1'b0;
      rep_first_r <= 1'b0;
    end else if (rep_fire_s) begin
      rep_cnt_r   <= {MSW{1'b0}};
      rep_first_r <= 1'b0;
    end else if (rep_armed_r && tick_s) begin
      rep_cnt_r <= rep_cnt_r + MSW'(1);
    end
  end
`endif

  // Adjust-mode FSM with registered mode, activity flag and increment pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r     <= MODE_NONE;
      adj_active <= 1'b0;
      inc_giay   <= 1'b0;
      inc_phut   <= 1'b0;
      inc_gio    <= 1'b0;
      idle_r     <= {MSW{1'b0}};
    end else begin
      inc_giay <= 1'b0;
      inc_phut <= 1'b0;
      inc_gio  <= 1'b0;
      if (mod_press_s) begin
        mode_r     <= next_mode_s;
        adj_active <= (next_mode_s != MODE_NONE);
        idle_r     <= {MSW{1'b0}};
      end else if (up_accept_s || rep_fire_s) begin
        case (mode_r)
          MODE_SEC:  inc_giay <= 1'b1;
          MODE_MIN:  inc_phut <= 1'b1;
          MODE_HOUR: inc_gio  <= 1'b1;
          default:   inc_giay <= 1'b0;
        endcase
        idle_r <= {MSW{1'b0}};
      end else if (mode_r == MODE_NONE) begin
        idle_r <= {MSW{1'b0}};
      end else if (timeout_s) begin
        // Inactivity: drop back to no-adjust without touching the counters.
        mode_r     <= MODE_NONE;
        adj_active <= 1'b0;
        idle_r     <= {MSW{1'b0}};
      end else if (tick_s) begin
        idle_r <= idle_r + MSW'(1);
      end
    end
  end

endmodule

// File: tb/tb_xuly_mod_chinh.sv
// Self-checking bench for xuly_mod_chinh (small timing parameters).
// The reference model works at press level: a mode press advances the mode
// modulo 4, an UP press in a non-zero mode adds one to that field's count.
module tb_xuly_mod_chinh;

  logic       clk;
  logic       rst;
  logic       btn_mod;
  logic       btn_tang;
  logic [1:0] gt_mod;
  logic       inc_giay;
  logic       inc_phut;
  logic       inc_gio;
  logic       adj_active;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int o_inc [3] = '{0, 0, 0};
  int m_inc [3] = '{0, 0, 0};
  int m_mode = 0;
  int multi_hot = 0;
  int wide = 0;
  bit p_g = 1'b0;
  bit p_p = 1'b0;
  bit p_h = 1'b0;
  int giay_t [$];

  xuly_mod_chinh #(
    .CLK_DIV(4), .DEB_MS(3), .TIMEOUT_MS(50), .REP_DELAY_MS(10), .REP_RATE_MS(5)
  ) dut (
    .clk(clk), .rst(rst), .btn_mod(btn_mod), .btn_tang(btn_tang),
    .gt_mod(gt_mod), .inc_giay(inc_giay), .inc_phut(inc_phut), .inc_gio(inc_gio),
    .adj_active(adj_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (inc_giay) begin
        o_inc[0] <= o_inc[0] + 1;
        giay_t.push_back(cyc);
      end
      if (inc_phut) o_inc[1] <= o_inc[1] + 1;
      if (inc_gio)  o_inc[2] <= o_inc[2] + 1;
      if (int'(inc_giay) + int'(inc_phut) + int'(inc_gio) > 1) multi_hot <= multi_hot + 1;
      if ((inc_giay && p_g) || (inc_phut && p_p) || (inc_gio && p_h)) wide <= wide + 1;
    end
    p_g <= inc_giay;
    p_p <= inc_phut;
    p_h <= inc_gio;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 400000)", $time);
    $fatal(1);
  end

  task automatic press(input bit use_mod, input bit use_up, input int hold, input int gap);
    @(posedge clk); #1;
    if (use_mod) btn_mod = 1'b1;
    if (use_up)  btn_tang = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    btn_mod  = 1'b0;
    btn_tang = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic model_press(input bit is_mod);
    if (is_mod) m_mode = (m_mode + 1) % 4;
    else if (m_mode != 0) m_inc[m_mode - 1]++;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_mod = 1'b0; btn_tang = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (gt_mod !== 2'b00) $display("FAIL reset_mode: got %0d expected 0", gt_mod);
    else pass_cnt++;
    total_cnt++;
    if (adj_active !== 1'b0) $display("FAIL reset_adj: got %0d expected 0", adj_active);
    else pass_cnt++;
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    total_cnt++;
    if (o_inc[0] + o_inc[1] + o_inc[2] !== 0)
      $display("FAIL reset_idle_pulses: got %0d expected 0", o_inc[0] + o_inc[1] + o_inc[2]);
    else pass_cnt++;
    total_cnt++;
    if (gt_mod !== 2'b00) $display("FAIL reset_idle_mode: got %0d expected 0", gt_mod);
    else pass_cnt++;
  endtask

  task automatic test_mode_step;
    press(1'b1, 1'b0, 4, 30);
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, $urandom_range(7, 1), 30);
    total_cnt++;
    if (gt_mod !== 2'b00) $display("FAIL bounce_mode: got %0d expected 0", gt_mod);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      press(1'b1, 1'b0, (k == 0) ? 20 : $urandom_range(28, 24), 30);
      model_press(1'b1);
      total_cnt++;
      if (gt_mod !== m_mode[1:0]) $display("FAIL step_mode[%0d]: got %0d expected %0d", k, gt_mod, m_mode);
      else pass_cnt++;
      total_cnt++;
      if (adj_active !== (m_mode != 0)) $display("FAIL step_adj[%0d]: got %0d expected %0d", k, adj_active, m_mode != 0);
      else pass_cnt++;
    end
  endtask

  task automatic test_up_pulse;
    bit is_mod;
    // UP in mode 00, then mode 10 and UP, then a random press mix.
    for (int k = 0; k < 23; k++) begin
      if (k == 0) is_mod = 1'b0;
      else if (k < 3) is_mod = 1'b1;
      else if (k == 3) is_mod = 1'b0;
      else is_mod = ($urandom_range(2, 0) == 0);
      press(is_mod, !is_mod, $urandom_range(28, 24), $urandom_range(32, 24));
      model_press(is_mod);
      total_cnt++;
      if (gt_mod !== m_mode[1:0]) $display("FAIL up_mode[%0d]: got %0d expected %0d", k, gt_mod, m_mode);
      else pass_cnt++;
      total_cnt++;
      if (adj_active !== (m_mode != 0)) $display("FAIL up_adj[%0d]: got %0d expected %0d", k, adj_active, m_mode != 0);
      else pass_cnt++;
      for (int f = 0; f < 3; f++) begin
        total_cnt++;
        if (o_inc[f] !== m_inc[f]) $display("FAIL up_count[%0d] field %0d: got %0d expected %0d", k, f, o_inc[f], m_inc[f]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_timeout;
    int t0;
    for (int pass = 0; pass < 2; pass++) begin
      while (m_mode != 0) begin
        press(1'b1, 1'b0, 26, 26);
        model_press(1'b1);
      end
      press(1'b1, 1'b0, 26, 26);
      press(1'b1, 1'b0, 26, 26);
      @(posedge clk); #1;
      t0 = cyc;
      btn_mod = 1'b1;
      repeat (26) @(posedge clk);
      #1;
      btn_mod = 1'b0;
      m_mode = 3;
      if (pass == 0) begin
        wait_until(t0 + 195);
        total_cnt++;
        if (gt_mod !== 2'b11) $display("FAIL timeout_before: got %0d expected 3", gt_mod);
        else pass_cnt++;
        wait_until(t0 + 230);
      end else begin
        wait_until(t0 + 160);
        btn_tang = 1'b1;
        repeat (26) @(posedge clk);
        #1;
        btn_tang = 1'b0;
        m_inc[2]++;
        wait_until(t0 + 240);
        total_cnt++;
        if (gt_mod !== 2'b11) $display("FAIL timeout_press_kept: got %0d expected 3", gt_mod);
        else pass_cnt++;
        total_cnt++;
        if (o_inc[2] !== m_inc[2]) $display("FAIL timeout_press_inc: got %0d expected %0d", o_inc[2], m_inc[2]);
        else pass_cnt++;
        wait_until(t0 + 420);
      end
      m_mode = 0;
      total_cnt++;
      if (gt_mod !== 2'b00) $display("FAIL timeout_mode[%0d]: got %0d expected 0", pass, gt_mod);
      else pass_cnt++;
      total_cnt++;
      if (adj_active !== 1'b0) $display("FAIL timeout_adj[%0d]: got %0d expected 0", pass, adj_active);
      else pass_cnt++;
    end
  endtask

  task automatic test_simultaneous;
    press(1'b1, 1'b0, 26, 28);
    model_press(1'b1);
    press(1'b1, 1'b1, 26, 28);
    model_press(1'b1);
    total_cnt++;
    if (gt_mod !== 2'b10) $display("FAIL simul_mode: got %0d expected 2", gt_mod);
    else pass_cnt++;
    for (int f = 0; f < 3; f++) begin
      total_cnt++;
      if (o_inc[f] !== m_inc[f]) $display("FAIL simul_count field %0d: got %0d expected %0d", f, o_inc[f], m_inc[f]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_held;
    @(posedge clk); #1;
    btn_tang = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    m_inc[1]++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_mode = 0;
    total_cnt++;
    if (gt_mod !== 2'b00) $display("FAIL rst_held_mode: got %0d expected 0", gt_mod);
    else pass_cnt++;
    total_cnt++;
    if (adj_active !== 1'b0) $display("FAIL rst_held_adj: got %0d expected 0", adj_active);
    else pass_cnt++;
    press(1'b1, 1'b0, 26, 30);
    model_press(1'b1);
    repeat (60) @(posedge clk);
    #1;
    btn_tang = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    total_cnt++;
    if (gt_mod !== 2'b01) $display("FAIL rst_held_step: got %0d expected 1", gt_mod);
    else pass_cnt++;
    for (int f = 0; f < 3; f++) begin
      total_cnt++;
      if (o_inc[f] !== m_inc[f]) $display("FAIL rst_held_nopulse field %0d: got %0d expected %0d", f, o_inc[f], m_inc[f]);
      else pass_cnt++;
    end
    press(1'b0, 1'b1, 26, 30);
    model_press(1'b0);
    total_cnt++;
    if (o_inc[0] !== m_inc[0]) $display("FAIL rst_held_repress: got %0d expected %0d", o_inc[0], m_inc[0]);
    else pass_cnt++;
  endtask

`ifdef AUTO_REPEAT_EN
  task automatic test_repeat;
    int d;
    giay_t.delete();
    press(1'b0, 1'b1, 132, 30);
    m_inc[0] += 6;
    total_cnt++;
    if (giay_t.size() !== 6) $display("FAIL repeat_count: got %0d expected 6", giay_t.size());
    else pass_cnt++;
    if (giay_t.size() == 6) begin
      for (int k = 1; k < 6; k++) begin
        d = giay_t[k] - giay_t[k - 1];
        total_cnt++;
        if ((k == 1) ? (d < 36 || d > 41) : (d !== 20))
          $display("FAIL repeat_gap[%0d]: got %0d clk expected %0s", k, d, (k == 1) ? "36..41" : "20");
        else pass_cnt++;
      end
    end
  endtask
`endif

  task automatic test_pulse_shape;
    total_cnt++;
    if (multi_hot !== 0) $display("FAIL onehot: got %0d multi-hot clk expected 0", multi_hot);
    else pass_cnt++;
    total_cnt++;
    if (wide !== 0) $display("FAIL pulse_width: got %0d wide pulses expected 0", wide);
    else pass_cnt++;
    for (int f = 0; f < 3; f++) begin
      total_cnt++;
      if (o_inc[f] !== m_inc[f]) $display("FAIL final_count field %0d: got %0d expected %0d", f, o_inc[f], m_inc[f]);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_mod = 1'b0;
    btn_tang = 1'b0;
    test_reset;
    test_mode_step;
    test_up_pulse;
    test_timeout;
    test_simultaneous;
    test_reset_held;
`ifdef AUTO_REPEAT_EN
    test_repeat;
`endif
    test_pulse_shape;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
